rf_wb_scheduler: RTL and testbench

Write-port scheduler and scoreboard for the 32x32 register file. It tracks registers that have an outstanding write and stalls issue on RAW/WAW hazards. It arbitrates two writeback sources (execute and load) onto the single register-file write port, using round-robin with a registered output stage. It sits between issue/writeback and the register file, and drives the file's rd_addr, rf_wr_en and wr_data.

---
 rtl/rf_ctrl_pkg.sv | 18 +
 rtl/rf_scoreboard.sv | 52 +++++
 rtl/rf_wb_scheduler.sv | 111 +++++++++++
 tb/tb_rf_wb_scheduler.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file write scheduler.
package rf_ctrl_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;

  typedef enum logic {
    WB_SRC_EX = 1'b0,
    WB_SRC_LD = 1'b1
  } wb_src_e;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-register scoreboard: one bit per architectural register with an
// outstanding write, plus the RAW/WAW hazard check for the issue stage.
module rf_scoreboard
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REGS = rf_ctrl_pkg::NUM_REGS,
  parameter int ADDR_W   = rf_ctrl_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                iss_valid,
  input  logic [ADDR_W-1:0]   iss_rs1_addr,
  input  logic                iss_rs1_used,
  input  logic [ADDR_W-1:0]   iss_rs2_addr,
  input  logic                iss_rs2_used,
  input  logic [ADDR_W-1:0]   iss_rd_addr,
  input  logic                iss_rd_wen,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_addr,
  output logic                iss_stall,
  output logic [NUM_REGS-1:0] busy_vec
);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic                set_en;

  assign iss_stall = iss_valid &
                     ((iss_rs1_used & busy_q[iss_rs1_addr]) |
                      (iss_rs2_used & busy_q[iss_rs2_addr]) |
                      (iss_rd_wen & (iss_rd_addr != '0) & busy_q[iss_rd_addr]));

  assign set_en = iss_valid & ~iss_stall & iss_rd_wen & (iss_rd_addr != '0);

  // NOTE: every always_comb output gets a full default first so no path leaves it unassigned (no latch).
  always_comb begin
    busy_d = busy_q;
    if (clr_en) busy_d[clr_addr] = 1'b0;
    // Set is applied after clear so a same-cycle set of the same register wins.
    if (set_en) busy_d[iss_rd_addr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so all flops sample pre-edge values.
  // NOTE: busy_q is a flop vector, not a RAM, so clearing it on reset is both cheap and required.
  always_ff @(posedge clk) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// Write-port scheduler: round-robin arbitration of execute/load writebacks onto
// the single register-file write port, with a registered write stage and scoreboard.
module rf_wb_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REGS    = rf_ctrl_pkg::NUM_REGS,
  parameter int ADDR_W      = rf_ctrl_pkg::ADDR_W,
  parameter int DATA_W      = rf_ctrl_pkg::DATA_W,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   iss_valid,
  input  logic [ADDR_W-1:0]      iss_rs1_addr,
  input  logic                   iss_rs1_used,
  input  logic [ADDR_W-1:0]      iss_rs2_addr,
  input  logic                   iss_rs2_used,
  input  logic [ADDR_W-1:0]      iss_rd_addr,
  input  logic                   iss_rd_wen,
  output logic                   iss_stall,
  input  logic                   ex_wb_valid,
  input  logic [ADDR_W-1:0]      ex_wb_rd,
  input  logic [DATA_W-1:0]      ex_wb_data,
  output logic                   ex_wb_ready,
  input  logic                   ld_wb_valid,
  input  logic [ADDR_W-1:0]      ld_wb_rd,
  input  logic [DATA_W-1:0]      ld_wb_data,
  output logic                   ld_wb_ready,
  output logic [ADDR_W-1:0]      rf_rd_addr,
  output logic                   rf_wr_en,
  output logic [DATA_W-1:0]      rf_wr_data,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic                   err_spurious_wb,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  wb_src_e          rr_q, rr_d;
  logic             ex_gnt, ld_gnt, any_gnt, spurious;
  wb_req_t          gnt_req;
  logic [ADDR_W-1:0] rf_rd_addr_q;
  logic [DATA_W-1:0] rf_wr_data_q;
  logic             rf_wr_en_q, err_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset_n      (reset_n),
    .iss_valid    (iss_valid),
    .iss_rs1_addr (iss_rs1_addr),
    .iss_rs1_used (iss_rs1_used),
    .iss_rs2_addr (iss_rs2_addr),
    .iss_rs2_used (iss_rs2_used),
    .iss_rd_addr  (iss_rd_addr),
    .iss_rd_wen   (iss_rd_wen),
    .clr_en       (rf_wr_en_q),
    .clr_addr     (rf_rd_addr_q),
    .iss_stall    (iss_stall),
    .busy_vec     (busy_vec)
  );

  // rr_q names the source that wins the next contention.
  always_comb begin
    ex_gnt  = 1'b0;
    ld_gnt  = 1'b0;
    rr_d    = rr_q;
    gnt_req = '{rd: ex_wb_rd, data: ex_wb_data};
    if (reset_n) begin
      if (ex_wb_valid && (!ld_wb_valid || rr_q == WB_SRC_EX)) ex_gnt = 1'b1;
      else if (ld_wb_valid)                                   ld_gnt = 1'b1;
      if (ex_wb_valid && ld_wb_valid) rr_d = ex_gnt ? WB_SRC_LD : WB_SRC_EX;
    end
    if (ld_gnt) gnt_req = '{rd: ld_wb_rd, data: ld_wb_data};
  end

  assign any_gnt  = ex_gnt | ld_gnt;
  assign spurious = any_gnt & (gnt_req.rd != '0) & ~busy_vec[gnt_req.rd];

  assign stall_cnt_d = (iss_stall && stall_cnt_q != '1) ? stall_cnt_q + 1'b1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rr_q         <= WB_SRC_EX;
      rf_rd_addr_q <= '0;
      rf_wr_data_q <= '0;
      rf_wr_en_q   <= 1'b0;
      err_q        <= 1'b0;
      stall_cnt_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      rf_wr_en_q  <= any_gnt & (gnt_req.rd != '0);
      err_q       <= err_q | spurious;
      stall_cnt_q <= stall_cnt_d;
      if (any_gnt) begin
        rf_rd_addr_q <= gnt_req.rd;
        rf_wr_data_q <= gnt_req.data;
      end
    end
  end

  assign ex_wb_ready     = ex_gnt;
  assign ld_wb_ready     = ld_gnt;
  assign rf_rd_addr      = rf_rd_addr_q;
  assign rf_wr_data      = rf_wr_data_q;
  assign rf_wr_en        = rf_wr_en_q;
  assign err_spurious_wb = err_q;
  assign stall_cycles    = stall_cnt_q;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Self-checking bench for rf_wb_scheduler: directed scenarios plus a randomized
// run against a behavioural model of the scoreboard, arbiter and write stage.
module tb_rf_wb_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 32;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          iss_valid, iss_rs1_used, iss_rs2_used, iss_rd_wen;
  logic [AW-1:0] iss_rs1_addr, iss_rs2_addr, iss_rd_addr;
  logic          iss_stall;
  logic          ex_wb_valid, ex_wb_ready, ld_wb_valid, ld_wb_ready;
  logic [AW-1:0] ex_wb_rd, ld_wb_rd;
  logic [DW-1:0] ex_wb_data, ld_wb_data;
  logic [AW-1:0] rf_rd_addr;
  logic          rf_wr_en;
  logic [DW-1:0] rf_wr_data;
  logic [NR-1:0] busy_vec;
  logic          err_spurious_wb;
  logic [SW-1:0] stall_cycles;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler dut (
    .clk(clk), .reset_n(reset_n),
    .iss_valid(iss_valid), .iss_rs1_addr(iss_rs1_addr), .iss_rs1_used(iss_rs1_used),
    .iss_rs2_addr(iss_rs2_addr), .iss_rs2_used(iss_rs2_used),
    .iss_rd_addr(iss_rd_addr), .iss_rd_wen(iss_rd_wen), .iss_stall(iss_stall),
    .ex_wb_valid(ex_wb_valid), .ex_wb_rd(ex_wb_rd), .ex_wb_data(ex_wb_data), .ex_wb_ready(ex_wb_ready),
    .ld_wb_valid(ld_wb_valid), .ld_wb_rd(ld_wb_rd), .ld_wb_data(ld_wb_data), .ld_wb_ready(ld_wb_ready),
    .rf_rd_addr(rf_rd_addr), .rf_wr_en(rf_wr_en), .rf_wr_data(rf_wr_data),
    .busy_vec(busy_vec), .err_spurious_wb(err_spurious_wb), .stall_cycles(stall_cycles)
  );

  initial begin
    #200us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic idle();
    iss_valid = 0; iss_rs1_used = 0; iss_rs2_used = 0; iss_rd_wen = 0;
    iss_rs1_addr = 0; iss_rs2_addr = 0; iss_rd_addr = 0;
    ex_wb_valid = 0; ex_wb_rd = 0; ex_wb_data = 0;
    ld_wb_valid = 0; ld_wb_rd = 0; ld_wb_data = 0;
  endtask

  task automatic do_reset();
    idle();
    reset_n = 0;
    tick(); tick();
    reset_n = 1;
  endtask

  task automatic issue_rd(input logic [AW-1:0] rd);
    iss_valid = 1; iss_rd_wen = 1; iss_rd_addr = rd;
    settle(); tick(); idle();
  endtask

  task automatic test_reset();
    idle();
    reset_n = 0;
    ex_wb_valid = 1; ex_wb_rd = 4; ld_wb_valid = 1; ld_wb_rd = 6;
    settle();
    total++; if (ex_wb_ready !== 1'b0) begin bad++; $display("FAIL reset_ex_ready got=%0b exp=0", ex_wb_ready); end
    total++; if (ld_wb_ready !== 1'b0) begin bad++; $display("FAIL reset_ld_ready got=%0b exp=0", ld_wb_ready); end
    tick(); tick();
    idle(); reset_n = 1;
    settle();
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL reset_busy got=%h exp=0", busy_vec); end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL reset_wr_en got=%0b exp=0", rf_wr_en); end
    total++; if (rf_rd_addr !== '0) begin bad++; $display("FAIL reset_rd_addr got=%0d exp=0", rf_rd_addr); end
    total++; if (rf_wr_data !== '0) begin bad++; $display("FAIL reset_wr_data got=%h exp=0", rf_wr_data); end
    total++; if (err_spurious_wb !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", err_spurious_wb); end
    total++; if (stall_cycles !== '0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cycles); end
    tick();
  endtask

  task automatic test_basic_wb();
    do_reset();
    issue_rd(5);
    ex_wb_valid = 1; ex_wb_rd = 5; ex_wb_data = 32'hDEADBEEF;
    settle();
    total++; if (busy_vec[5] !== 1'b1) begin bad++; $display("FAIL basic_busy_set got=%0b exp=1", busy_vec[5]); end
    total++; if (ex_wb_ready !== 1'b1) begin bad++; $display("FAIL basic_ex_ready got=%0b exp=1", ex_wb_ready); end
    tick(); idle();
    settle();
    total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL basic_wr_en got=%0b exp=1", rf_wr_en); end
    total++; if (rf_rd_addr !== 5'd5) begin bad++; $display("FAIL basic_rd_addr got=%0d exp=5", rf_rd_addr); end
    total++; if (rf_wr_data !== 32'hDEADBEEF) begin bad++; $display("FAIL basic_wr_data got=%h exp=deadbeef", rf_wr_data); end
    total++; if (busy_vec[5] !== 1'b1) begin bad++; $display("FAIL basic_busy_hold got=%0b exp=1", busy_vec[5]); end
    tick();
    settle();
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL basic_busy_clear got=%h exp=0", busy_vec); end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL basic_wr_en_pulse got=%0b exp=0", rf_wr_en); end
    total++; if (err_spurious_wb !== 1'b0) begin bad++; $display("FAIL basic_err got=%0b exp=0", err_spurious_wb); end
    tick();
  endtask

  // Writeback granted in cycle 3, rf_wr_en in cycle 4, dependent issues in cycle 5.
  task automatic test_raw_stall();
    logic exp_stall;
    do_reset();
    issue_rd(3);
    for (int c = 1; c <= 5; c++) begin
      iss_valid = 1; iss_rs1_used = 1; iss_rs1_addr = 3; iss_rd_wen = 0;
      ex_wb_valid = (c == 3); ex_wb_rd = 3; ex_wb_data = 32'h0000_0033;
      exp_stall = (c <= 4);
      settle();
      total++; if (iss_stall !== exp_stall) begin bad++; $display("FAIL raw_stall_c%0d got=%0b exp=%0b", c, iss_stall, exp_stall); end
      if (c == 4) begin
        total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL raw_wr_en got=%0b exp=1", rf_wr_en); end
      end
      tick();
    end
    idle();
    settle();
    total++; if (stall_cycles !== 16'd4) begin bad++; $display("FAIL raw_stall_cnt got=%0d exp=4", stall_cycles); end
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL raw_busy got=%h exp=0", busy_vec); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic exp_ex;
    logic [AW-1:0] exp_addr;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      ex_wb_valid = 1; ex_wb_rd = 1; ex_wb_data = 32'hAAAA_0001;
      ld_wb_valid = 1; ld_wb_rd = 2; ld_wb_data = 32'hBBBB_0002;
      exp_ex = (k % 2 == 0);
      settle();
      total++; if (ex_wb_ready !== exp_ex) begin bad++; $display("FAIL b2b_ex_ready_k%0d got=%0b exp=%0b", k, ex_wb_ready, exp_ex); end
      total++; if (ld_wb_ready !== !exp_ex) begin bad++; $display("FAIL b2b_ld_ready_k%0d got=%0b exp=%0b", k, ld_wb_ready, !exp_ex); end
      if (k > 0) begin
        exp_addr = (k % 2 == 1) ? 5'd1 : 5'd2;
        total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL b2b_wr_en_k%0d got=%0b exp=1", k, rf_wr_en); end
        total++; if (rf_rd_addr !== exp_addr) begin bad++; $display("FAIL b2b_addr_k%0d got=%0d exp=%0d", k, rf_rd_addr, exp_addr); end
      end
      tick();
    end
    idle();
    settle();
    total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL b2b_wr_en_last got=%0b exp=1", rf_wr_en); end
    total++; if (rf_rd_addr !== 5'd2) begin bad++; $display("FAIL b2b_addr_last got=%0d exp=2", rf_rd_addr); end
    total++; if (rf_wr_data !== 32'hBBBB_0002) begin bad++; $display("FAIL b2b_data_last got=%h exp=bbbb0002", rf_wr_data); end
    tick();
    settle();
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL b2b_wr_en_off got=%0b exp=0", rf_wr_en); end
    tick();
  endtask

  task automatic test_rd_zero();
    do_reset();
    ld_wb_valid = 1; ld_wb_rd = 0; ld_wb_data = 32'h12345678;
    settle();
    total++; if (ld_wb_ready !== 1'b1) begin bad++; $display("FAIL rd0_ld_ready got=%0b exp=1", ld_wb_ready); end
    tick(); idle();
    settle();
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL rd0_wr_en got=%0b exp=0", rf_wr_en); end
    total++; if (rf_wr_data !== 32'h12345678) begin bad++; $display("FAIL rd0_wr_data got=%h exp=12345678", rf_wr_data); end
    total++; if (err_spurious_wb !== 1'b0) begin bad++; $display("FAIL rd0_err got=%0b exp=0", err_spurious_wb); end
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL rd0_busy got=%h exp=0", busy_vec); end
    tick();
  endtask

  task automatic test_spurious();
    do_reset();
    ex_wb_valid = 1; ex_wb_rd = 7; ex_wb_data = 32'h0000_0077;
    settle();
    total++; if (ex_wb_ready !== 1'b1) begin bad++; $display("FAIL spur_ex_ready got=%0b exp=1", ex_wb_ready); end
    tick(); idle();
    settle();
    total++; if (err_spurious_wb !== 1'b1) begin bad++; $display("FAIL spur_err_set got=%0b exp=1", err_spurious_wb); end
    total++; if (rf_wr_en !== 1'b1) begin bad++; $display("FAIL spur_wr_en got=%0b exp=1", rf_wr_en); end
    total++; if (rf_rd_addr !== 5'd7) begin bad++; $display("FAIL spur_addr got=%0d exp=7", rf_rd_addr); end
    tick(); tick(); tick();
    settle();
    total++; if (err_spurious_wb !== 1'b1) begin bad++; $display("FAIL spur_err_sticky got=%0b exp=1", err_spurious_wb); end
    reset_n = 0;
    tick();
    reset_n = 1;
    settle();
    total++; if (err_spurious_wb !== 1'b0) begin bad++; $display("FAIL spur_err_cleared got=%0b exp=0", err_spurious_wb); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    issue_rd(9);
    settle();
    total++; if (busy_vec[9] !== 1'b1) begin bad++; $display("FAIL rmid_busy_set got=%0b exp=1", busy_vec[9]); end
    tick();
    reset_n = 0;
    ex_wb_valid = 1; ex_wb_rd = 9; ex_wb_data = 32'h9999_9999;
    settle();
    total++; if (ex_wb_ready !== 1'b0) begin bad++; $display("FAIL rmid_ex_ready got=%0b exp=0", ex_wb_ready); end
    tick();
    reset_n = 1; idle();
    settle();
    total++; if (busy_vec !== '0) begin bad++; $display("FAIL rmid_busy got=%h exp=0", busy_vec); end
    total++; if (rf_wr_en !== 1'b0) begin bad++; $display("FAIL rmid_wr_en got=%0b exp=0", rf_wr_en); end
    tick();
  endtask

  // Behavioural model: the busy set, a "who wins next tie" flag, and the pending write.
  task automatic test_random();
    logic [NR-1:0] m_busy, n_busy;
    logic          m_pref_ex, m_wen, m_err;
    logic [AW-1:0] m_addr, g_rd;
    logic [DW-1:0] m_data, g_data;
    int            m_scnt;
    logic          e_stall, e_ex, e_ld, ex_hold, ld_hold;
    do_reset();
    m_busy = '0; m_pref_ex = 1; m_wen = 0; m_err = 0; m_addr = 0; m_data = 0; m_scnt = 0;
    ex_hold = 0; ld_hold = 0;
    for (int n = 0; n < 400; n++) begin
      iss_valid    = ($urandom_range(0, 9) < 6);
      iss_rs1_used = 1'($urandom_range(0, 1));
      iss_rs2_used = 1'($urandom_range(0, 1));
      iss_rd_wen   = 1'($urandom_range(0, 1));
      iss_rs1_addr = AW'($urandom_range(0, 7));
      iss_rs2_addr = AW'($urandom_range(0, 7));
      iss_rd_addr  = AW'($urandom_range(0, 7));
      if (!ex_hold) begin
        ex_wb_valid = 1'($urandom_range(0, 1));
        ex_wb_rd = AW'($urandom_range(0, 7)); ex_wb_data = $urandom;
      end
      if (!ld_hold) begin
        ld_wb_valid = 1'($urandom_range(0, 1));
        ld_wb_rd = AW'($urandom_range(0, 7)); ld_wb_data = $urandom;
      end
      settle();
      e_stall = iss_valid && ((iss_rs1_used && m_busy[iss_rs1_addr]) ||
                              (iss_rs2_used && m_busy[iss_rs2_addr]) ||
                              (iss_rd_wen && iss_rd_addr != 0 && m_busy[iss_rd_addr]));
      e_ex = ex_wb_valid && (!ld_wb_valid || m_pref_ex);
      e_ld = ld_wb_valid && !e_ex;
      total++; if (iss_stall !== e_stall) begin bad++; $display("FAIL rnd_stall n=%0d got=%0b exp=%0b", n, iss_stall, e_stall); end
      total++; if (ex_wb_ready !== e_ex) begin bad++; $display("FAIL rnd_ex_ready n=%0d got=%0b exp=%0b", n, ex_wb_ready, e_ex); end
      total++; if (ld_wb_ready !== e_ld) begin bad++; $display("FAIL rnd_ld_ready n=%0d got=%0b exp=%0b", n, ld_wb_ready, e_ld); end
      total++; if (busy_vec !== m_busy) begin bad++; $display("FAIL rnd_busy n=%0d got=%h exp=%h", n, busy_vec, m_busy); end
      total++; if (rf_wr_en !== m_wen) begin bad++; $display("FAIL rnd_wr_en n=%0d got=%0b exp=%0b", n, rf_wr_en, m_wen); end
      total++; if (rf_rd_addr !== m_addr) begin bad++; $display("FAIL rnd_addr n=%0d got=%0d exp=%0d", n, rf_rd_addr, m_addr); end
      total++; if (rf_wr_data !== m_data) begin bad++; $display("FAIL rnd_data n=%0d got=%h exp=%h", n, rf_wr_data, m_data); end
      total++; if (err_spurious_wb !== m_err) begin bad++; $display("FAIL rnd_err n=%0d got=%0b exp=%0b", n, err_spurious_wb, m_err); end
      total++; if (stall_cycles !== SW'(m_scnt)) begin bad++; $display("FAIL rnd_stall_cnt n=%0d got=%0d exp=%0d", n, stall_cycles, m_scnt); end
      n_busy = m_busy;
      if (m_wen) n_busy[m_addr] = 1'b0;
      if (iss_valid && !e_stall && iss_rd_wen && iss_rd_addr != 0) n_busy[iss_rd_addr] = 1'b1;
      if (e_ex || e_ld) begin
        g_rd   = e_ex ? ex_wb_rd : ld_wb_rd;
        g_data = e_ex ? ex_wb_data : ld_wb_data;
        if (g_rd != 0 && !m_busy[g_rd]) m_err = 1'b1;
        m_wen = (g_rd != 0); m_addr = g_rd; m_data = g_data;
      end else begin
        m_wen = 1'b0;
      end
      if (ex_wb_valid && ld_wb_valid) m_pref_ex = !e_ex;
      if (e_stall && m_scnt < 65535) m_scnt++;
      m_busy  = n_busy;
      ex_hold = ex_wb_valid && !e_ex;
      ld_hold = ld_wb_valid && !e_ld;
      tick();
    end
    idle();
  endtask

  initial begin
    idle();
    reset_n = 0;
    test_reset();
    test_basic_wb();
    test_raw_stall();
    test_back_to_back();
    test_rd_zero();
    test_spurious();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
